// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: default address width and FSM encoding.
package branch_resolver_pkg;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } br_state_e;
endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Saturating performance counter; holds at all-ones and freezes while rdy=0.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt <= '0;
    else if (rdy && inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: trains the predictor one cycle after resolve and
// flushes/redirects the front end for FLUSH_CYCLES cycles on a mispredict.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              ex_is_cond,
  input  logic              ex_is_jump,
  input  logic              ex_cond_true,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  output logic              is_branch,
  output logic [ADDR_W-1:0] ex_pc,
  output logic [ADDR_W-1:0] b_tar_o,
  output logic              taken_o,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int            FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  br_state_e         state;
  logic [FC_W-1:0]   cnt;
  logic              resolve, act_taken, mispredict;
  logic [ADDR_W-1:0] fall_pc, act_next, pred_next;

  // Fallthrough wraps at the top of the address space by design.
  assign fall_pc    = ex_pc_i + ADDR_W'(4);
  assign act_taken  = ex_is_jump | (ex_is_cond & ex_cond_true);
  assign act_next   = act_taken  ? ex_target   : fall_pc;
  assign pred_next  = pred_taken ? pred_target : fall_pc;
  assign resolve    = rdy & ex_valid & (ex_is_cond | ex_is_jump) & (state == S_IDLE);
  assign mispredict = resolve & (act_next != pred_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_branch   <= 1'b0;
      ex_pc       <= '0;
      b_tar_o     <= '0;
      taken_o     <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else if (rdy) begin
      is_branch <= resolve;
      if (resolve) begin
        ex_pc   <= ex_pc_i;
        b_tar_o <= ex_target;
        taken_o <= act_taken;
      end
      case (state)
        S_IDLE: begin
          flush <= 1'b0;
          if (mispredict) begin
            state       <= S_FLUSH;
            flush       <= 1'b1;
            cnt         <= FC_LOAD;
            redirect_pc <= act_next;
          end
        end
        S_FLUSH: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk(clk), .rst(rst), .rdy(rdy), .inc(resolve),    .cnt(br_count)
  );
  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst(rst), .rdy(rdy), .inc(mispredict), .cnt(miss_count)
  );
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench: predictor-update scoreboard plus inline flush/counter checks.
module tb_branch_resolver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc_i = '0;
  logic        ex_is_cond = 1'b0, ex_is_jump = 1'b0, ex_cond_true = 1'b0;
  logic [31:0] ex_target = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        is_branch, taken_o, flush;
  logic [31:0] ex_pc, b_tar_o, redirect_pc, br_count, miss_count;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tar;
    logic        taken;
  } upd_t;
  upd_t exp_q[$];
  logic live = 1'b0;

  branch_resolver dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ex_valid(ex_valid), .ex_pc_i(ex_pc_i),
    .ex_is_cond(ex_is_cond), .ex_is_jump(ex_is_jump), .ex_cond_true(ex_cond_true),
    .ex_target(ex_target), .pred_taken(pred_taken), .pred_target(pred_target),
    .is_branch(is_branch), .ex_pc(ex_pc), .b_tar_o(b_tar_o), .taken_o(taken_o),
    .flush(flush), .redirect_pc(redirect_pc), .br_count(br_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // A pulse only counts as a fresh update if the preceding edge was a ready one.
  always @(posedge clk) live <= rdy;

  always @(negedge clk) begin
    if (rst && live && is_branch) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_update: pc 0x%08h, none expected", ex_pc);
      end else begin
        upd_t e;
        e = exp_q.pop_front();
        check("upd_pc",    ex_pc,          e.pc);
        check("upd_tar",   b_tar_o,        e.tar);
        check("upd_taken", 32'(taken_o),   32'(e.taken));
      end
    end
  end

  // Call at a negedge; presents one EX instruction across one rising edge.
  task automatic issue(input logic [31:0] pc, input logic c, input logic j, input logic t,
                       input logic [31:0] tar, input logic pt, input logic [31:0] ptar,
                       input logic push, input logic exp_taken);
    ex_valid = 1'b1; ex_pc_i = pc; ex_is_cond = c; ex_is_jump = j; ex_cond_true = t;
    ex_target = tar; pred_taken = pt; pred_target = ptar;
    if (push) exp_q.push_back('{pc, tar, exp_taken});
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_is_branch", 32'(is_branch), 32'h0);
    check("rst_flush",     32'(flush),     32'h0);
    check("rst_redirect",  redirect_pc,    32'h0);
    check("rst_ex_pc",     ex_pc,          32'h0);
    check("rst_br",        br_count,       32'h0);
    check("rst_miss",      miss_count,     32'h0);
    rst = 1'b1;
    idle_cycle();

    // 1: correctly predicted taken branch
    issue(32'h40, 1, 0, 1, 32'h100, 1, 32'h100, 1, 1);
    check("t1_flush", 32'(flush), 32'h0);
    check("t1_br",    br_count,   32'd1);
    check("t1_miss",  miss_count, 32'd0);
    idle_cycle();
    check("t1_flush_after", 32'(flush), 32'h0);

    // 2: predicted taken, actually not taken
    issue(32'h40, 1, 0, 0, 32'h100, 1, 32'h100, 1, 0);
    check("t2_flush0",   32'(flush),  32'h1);
    check("t2_redirect", redirect_pc, 32'h44);
    check("t2_miss",     miss_count,  32'd1);
    check("t2_br",       br_count,    32'd2);
    idle_cycle();
    check("t2_flush1", 32'(flush), 32'h1);
    idle_cycle();
    check("t2_flush_end", 32'(flush), 32'h0);

    // 3: JAL with right direction, wrong target; 4: branches during FLUSH dropped
    issue(32'h80, 0, 1, 0, 32'h200, 1, 32'h180, 1, 1);
    check("t3_flush",    32'(flush),  32'h1);
    check("t3_redirect", redirect_pc, 32'h200);
    check("t3_miss",     miss_count,  32'd2);
    issue(32'h300, 1, 0, 1, 32'h340, 0, 32'h0, 0, 0);
    check("t4_flush_mid", 32'(flush), 32'h1);
    issue(32'h300, 1, 0, 1, 32'h340, 0, 32'h0, 0, 0);
    check("t4_flush_end", 32'(flush),  32'h0);
    check("t4_br",        br_count,    32'd3);
    check("t4_miss",      miss_count,  32'd2);
    issue(32'h300, 1, 0, 1, 32'h340, 1, 32'h340, 1, 1);
    check("t4_resume_br",    br_count,   32'd4);
    check("t4_resume_flush", 32'(flush), 32'h0);
    issue(32'h400, 0, 0, 1, 32'h480, 1, 32'h480, 0, 0);
    check("nonbr_br", br_count, 32'd4);
    issue(32'h500, 1, 0, 0, 32'h580, 0, 32'h0, 1, 0);
    check("nt_ok_br",   br_count,   32'd5);
    check("nt_ok_miss", miss_count, 32'd2);

    // 5: freeze three cycles in the middle of a flush
    issue(32'h600, 1, 0, 1, 32'h700, 0, 32'h0, 1, 1);
    check("t5_redirect", redirect_pc, 32'h700);
    check("t5_miss",     miss_count,  32'd3);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check("t5_frozen_flush",    32'(flush),  32'h1);
      check("t5_frozen_redirect", redirect_pc, 32'h700);
      check("t5_frozen_br",       br_count,    32'd6);
    end
    rdy = 1'b1;
    idle_cycle();
    check("t5_flush_last", 32'(flush), 32'h1);
    idle_cycle();
    check("t5_flush_end", 32'(flush), 32'h0);

    // resolve held off by rdy=0 while IDLE, consumed once rdy returns
    rdy = 1'b0;
    ex_valid = 1'b1; ex_pc_i = 32'hA00; ex_is_cond = 1'b1; ex_is_jump = 1'b0;
    ex_cond_true = 1'b1; ex_target = 32'hA40; pred_taken = 1'b1; pred_target = 32'hA40;
    idle_cycle();
    check("rdy0_br",        br_count,        32'd6);
    check("rdy0_is_branch", 32'(is_branch),  32'h0);
    rdy = 1'b1;
    issue(32'hA00, 1, 0, 1, 32'hA40, 1, 32'hA40, 1, 1);
    check("rdy1_br", br_count, 32'd7);

    // 6: async reset between edges mid-flush
    issue(32'h800, 1, 0, 0, 32'h900, 1, 32'h900, 1, 0);
    check("t6_flush",    32'(flush),  32'h1);
    check("t6_redirect", redirect_pc, 32'h804);
    check("t6_br",       br_count,    32'd8);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_flush",     32'(flush),     32'h0);
    check("t6_rst_br",        br_count,       32'h0);
    check("t6_rst_miss",      miss_count,     32'h0);
    check("t6_rst_is_branch", 32'(is_branch), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
    issue(32'hFFFFFFFC, 1, 0, 0, 32'h10, 0, 32'h0, 1, 0);
    check("wrap_miss",  miss_count, 32'd0);
    check("wrap_br",    br_count,   32'd1);
    check("wrap_flush", 32'(flush), 32'h0);
    idle_cycle();
    idle_cycle();

    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_updates: %0d left, 0 expected", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
